// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, FSM encoding and shift helpers for alu_iter
//
// Purpose : common definitions imported by alu_iter_if, alu_comb and alu_iter.
// Ports   : none (package).
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // One bit position of the iterative shifter.
    function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                  input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            ALU_SLL: r = {v[XLEN-2:0], 1'b0};
            ALU_SRL: r = {1'b0, v[XLEN-1:1]};
            ALU_SRA: r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - request/response bundle between control FSM and alu_iter
//
// Purpose : groups the ALU handshake and data signals.
// Signals : alu_start/alu_op/alu_a/alu_b   request (master -> slave)
//           alu_busy/alu_done/alu_result/alu_zero  response (slave -> master)
interface alu_iter_if;
    import alu_pkg::*;

    logic            alu_start;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            alu_busy;
    logic            alu_done;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_busy, alu_done, alu_result, alu_zero
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_busy, alu_done, alu_result, alu_zero
    );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational single-cycle ALU ops (ADD..SLTU)
//
// Purpose : arithmetic/logic/compare result; any other opcode yields 0.
// Ports   : i_op     operation code
//           i_a      operand A
//           i_b      operand B
//           o_result combinational result
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    logic w_lt_s;
    logic w_lt_u;

    assign w_lt_s = $signed(i_a) < $signed(i_b);
    assign w_lt_u = i_a < i_b;

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - execute-stage ALU with bit-serial shifter and start/busy/done handshake
//
// Purpose : single-cycle ALU ops, shifts one bit per clock, registered result.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  alu_iter_if.slave (start/op/a/b in, busy/done/result/zero out)
module alu_iter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    alu_iter_if.slave  bus
);

    alu_state_e         r_state;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_op;

    logic [XLEN-1:0]    w_comb_result;
    logic [XLEN-1:0]    w_issue_result;
    logic [XLEN-1:0]    w_acc_next;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;

    alu_comb u_comb (
        .i_op     (bus.alu_op),
        .i_a      (bus.alu_a),
        .i_b      (bus.alu_b),
        .o_result (w_comb_result)
    );

    assign w_shamt    = bus.alu_b[SHAMT_W-1:0];
    assign w_is_shift = is_shift_op(bus.alu_op);

    // A zero-distance shift completes immediately with operand A unchanged.
    assign w_issue_result = w_is_shift ? bus.alu_a : w_comb_result;
    assign w_acc_next     = shift_one(r_op, r_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.alu_start) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_acc   <= bus.alu_a;
                            r_cnt   <= w_shamt;
                            r_op    <= bus.alu_op;
                        end else begin
                            r_result <= w_issue_result;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    // alu_start is deliberately not looked at here: requests
                    // arriving while busy are dropped, not queued.
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_busy   = r_busy;
    assign bus.alu_done   = r_done;
    assign bus.alu_result = r_result;
    assign bus.alu_zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter
module tb_alu_iter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if bus ();

    alu_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Behavioural reference: plain operators on the architectural operands.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned n;
        n = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << n;
            4'd8: return a >> n;
            4'd9: return 32'($signed(a) >>> n);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        int unsigned n;
        n = b % 32;
        if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && n != 0) return int'(n) + 1;
        return 1;
    endfunction

    // Issue one request, scramble the inputs after acceptance, and check
    // busy per cycle, done latency, result, zero flag and single-pulse done.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        bus.alu_start = 1'b1;
        bus.alu_op    = op;
        bus.alu_a     = a;
        bus.alu_b     = b;
        tick();
        bus.alu_start = 1'b0;
        bus.alu_op    = 4'($urandom);
        bus.alu_a     = $urandom;
        bus.alu_b     = $urandom;
        cyc = 1;
        while (!bus.alu_done && cyc < 40) begin
            chk({nm, "_busy"}, 32'(bus.alu_busy), 32'(cyc < lat));
            tick();
            cyc++;
        end
        chk({nm, "_done_seen"}, 32'(bus.alu_done), 32'd1);
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        chk({nm, "_result"}, bus.alu_result, exp);
        chk({nm, "_zero"}, 32'(bus.alu_zero), 32'(exp == 32'd0));
        chk({nm, "_busy_at_done"}, 32'(bus.alu_busy), 32'd0);
        tick();
        chk({nm, "_done_single"}, 32'(bus.alu_done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1};
        vecs[1]  = '{4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1};
        vecs[2]  = '{4'd9, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32};
        vecs[3]  = '{4'd7, 32'd1,         32'h0000_0024, 32'h0000_0010, 5};
        vecs[4]  = '{4'd8, 32'h1234_5678, 32'd0,         32'h1234_5678, 1};
        vecs[5]  = '{4'd5, 32'hFFFF_FFFF, 32'd1,         32'd1,         1};
        vecs[6]  = '{4'd6, 32'hFFFF_FFFF, 32'd1,         32'd0,         1};
        vecs[7]  = '{4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1};
        vecs[8]  = '{4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1};
        vecs[9]  = '{4'd12, 32'h1234_5678, 32'h1,        32'd0,         1};
        vecs[10] = '{4'd9, 32'h7000_0000, 32'd4,         32'h0700_0000, 5};
        vecs[11] = '{4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1,         32};

        bus.alu_start = 1'b0;
        bus.alu_op    = 4'd0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy",   32'(bus.alu_busy),   32'd0);
        chk("rst_done",   32'(bus.alu_done),   32'd0);
        chk("rst_result", bus.alu_result,      32'd0);
        chk("rst_zero",   32'(bus.alu_zero),   32'd1);

        // Directed vector table
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);

        // Back-to-back: ADD, then XOR issued in the ADD's done cycle
        bus.alu_start = 1'b1;
        bus.alu_op = 4'd0; bus.alu_a = 32'd100; bus.alu_b = 32'd23;
        tick();
        chk("b2b_done1", 32'(bus.alu_done), 32'd1);
        chk("b2b_res1",  bus.alu_result,    32'd123);
        bus.alu_op = 4'd4; bus.alu_a = 32'hAAAA_5555; bus.alu_b = 32'hFFFF_0000;
        tick();
        bus.alu_start = 1'b0;
        chk("b2b_done2", 32'(bus.alu_done), 32'd1);
        chk("b2b_res2",  bus.alu_result,    32'h5555_5555);
        tick();
        chk("b2b_done3", 32'(bus.alu_done), 32'd0);

        // Start while busy is dropped
        bus.alu_start = 1'b1;
        bus.alu_op = 4'd7; bus.alu_a = 32'd3; bus.alu_b = 32'd8;
        tick();
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.alu_done) begin
                ndone++;
                if (first == 0) first = c;
            end
            bus.alu_start = (c == 3);
            if (c == 3) begin
                bus.alu_op = 4'd0; bus.alu_a = 32'd1; bus.alu_b = 32'd2;
            end
            tick();
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_cycle", 32'(first), 32'd9);
        chk("busy_start_res",   bus.alu_result, 32'h0000_0300);

        // Reset in cycle 4 of an SRL n=10
        bus.alu_start = 1'b1;
        bus.alu_op = 4'd8; bus.alu_a = 32'hF000_0000; bus.alu_b = 32'd10;
        tick();
        bus.alu_start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   32'(bus.alu_busy), 32'd0);
        chk("abort_done",   32'(bus.alu_done), 32'd0);
        chk("abort_result", bus.alu_result,    32'd0);
        chk("abort_zero",   32'(bus.alu_zero), 32'd1);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.alu_done) ndone++;
            tick();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op("post_abort_and", 4'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_BEEF, 1);

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) a = 32'h8000_0000 | a;
            if (i % 4 == 0) b = b & 32'h0000_0007;
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_alu(op, a, b), ref_lat(op, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Execute-stage ALU directly downstream of the operand-B select mux.
- Consumes the selected 32-bit operand B, either register data or a zero-extended 5-bit shamt.
- Single-cycle arithmetic and logic ops; shifts are iterative, one bit position per clock, to save area.
- start/busy/done handshake toward the control FSM; registered result feeds writeback.

Parameters:
- XLEN, 32, datapath width of operands and result.
- SHAMT_W, 5, number of low bits of alu_b used as the shift amount.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- alu_start  input  1  request; accepted in any cycle where alu_busy=0.
- alu_op  input  4  operation code, captured on acceptance.
- alu_a  input  XLEN  operand A (rs1 data), captured on acceptance.
- alu_b  input  XLEN  operand B from the operand mux, captured on acceptance.
- alu_busy  output  1  high while a shift is in progress.
- alu_done  output  1  one-cycle pulse; alu_result is valid in this cycle.
- alu_result  output  XLEN  registered result, held until the next completion.
- alu_zero  output  1  combinational (alu_result == 0).

Behaviour:
- Interface fixed: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, alu_busy=0, alu_done=0, alu_result=0, alu_zero=1, internal counter and accumulator 0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA. Codes 10-15 produce result 0 with normal 1-cycle latency.
- Arithmetic wraps modulo 2^XLEN with no overflow flag. SLT/SLTU return 32'd1 or 32'd0.
- Shift amount n = alu_b[SHAMT_W-1:0]. Upper bits of alu_b are ignored for shifts.
- Cycle numbering: alu_start is high and sampled in cycle 0.
- Non-shift op, or shift with n=0: alu_result is updated at the end of cycle 0. alu_done=1 in cycle 1. alu_busy stays 0.
- Shift with n>0: FSM enters SHIFT with acc=alu_a and cnt=n.
  - Each SHIFT cycle shifts acc by 1: SLL shifts left and fills 0; SRL shifts right and fills 0; SRA shifts right and replicates bit XLEN-1. cnt then decrements.
  - When cnt==1, the shifted value is written to alu_result and the FSM returns to IDLE.
  - alu_busy=1 in cycles 1..n. alu_done=1 in cycle n+1.
- States: IDLE goes to SHIFT on (start & shift op & n!=0). SHIFT goes to IDLE when cnt==1. There are no other states.
- alu_start while alu_busy=1 is ignored; it is not queued.
- alu_start in a cycle where alu_done=1 (state IDLE) is accepted, giving back-to-back ops at 1/cycle.
- Input changes after acceptance do not affect the in-flight op.
- alu_done is never high for 2 consecutive cycles from a single request. Consecutive pulses occur only from back-to-back requests.
- rst mid-shift aborts the operation: the FSM returns to IDLE and no alu_done pulse is produced for the aborted op. rst has priority over alu_start.

Decomposition:
- Package alu_pkg holds the opcode localparams (ALU_ADD..ALU_SRA), XLEN, SHAMT_W, and the FSM state encoding.
- Sub-module alu_comb implements the purely combinational single-cycle ops (ADD..SLTU).
- alu_iter holds the handshake FSM, shift accumulator/counter and result register.

Test Plan:
- Reset: hold rst 2 cycles, then release -> busy=0, done=0, result=0, zero=1.
- ADD a=32'hFFFF_FFFF, b=1 -> done in cycle 1, result=0, zero=1. SUB a=5, b=7 -> result=32'hFFFF_FFFE.
- SRA a=32'h8000_0000, b=31 -> busy cycles 1..31, done cycle 32, result=32'hFFFF_FFFF. SLL a=1, b=32'h0000_0024 (shamt 4) -> result=32'h10, done cycle 5.
- SRL n=0, a=32'h1234_5678 -> done cycle 1, result unchanged, busy never high. Back-to-back: ADD, then XOR issued in the done cycle -> done pulses in 2 consecutive cycles with correct results.
- Start asserted during busy (SLL n=8 in flight, second start in cycle 3) -> ignored: exactly one done at cycle 9.
- rst asserted in cycle 4 of an SRL n=10 -> no done pulse, result=0, busy=0 next cycle; a fresh AND then completes normally.
